game_sequencer: RTL

//  Parametrised game-flow core for the obstacle game: generates the game tick enable,

---
 rtl/game_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game-flow core for the obstacle game: tick enable, MENU/PLAY/DEATH/VICTORY flow,
// obstacle scrolling, collision detection and lives/level/time bookkeeping.
module game_sequencer #(
  parameter int CLK_DIV     = 2083333,
  parameter int N_OBS       = 4,
  parameter int X_W         = 11,
  parameter int SCREEN_W    = 640,
  parameter int SPACING     = 160,
  parameter int PLAYER_X    = 100,
  parameter int PLAYER_W    = 16,
  parameter int OBS_W       = 16,
  parameter int OBS_H       = 32,
  parameter int LIVES       = 3,
  parameter int LEVEL_TICKS = 1200,
  parameter int MAX_LEVEL   = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 fast_mode,
  input  logic [9:0]           player_height,
  input  logic [N_OBS-1:0]     obs_en,
  output logic                 tick,
  output logic [1:0]           state,
  output logic                 menu_screen,
  output logic                 victory_screen,
  output logic                 player_death,
  output logic [N_OBS*X_W-1:0] obs_x,
  output logic [10:0]          game_time,
  output logic [2:0]           lives,
  output logic [2:0]           level
);

  typedef enum logic [1:0] {MENU = 2'd0, PLAY = 2'd1, DEATH = 2'd2, VICTORY = 2'd3} state_t;

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] LIM_NORM = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LIM_FAST = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [X_W-1:0]   WRAP_X   = X_W'(SCREEN_W + (N_OBS - 1) * SPACING);
  localparam logic [X_W-1:0]   HIT_LO   = X_W'(PLAYER_X - OBS_W + 1);
  localparam logic [X_W-1:0]   HIT_HI   = X_W'(PLAYER_X + PLAYER_W - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] divider, div_limit;
  logic             start_q, start_edge, hit;
  logic [X_W-1:0]   x_q [N_OBS];
  logic [X_W-1:0]   x_d [N_OBS];
  logic [X_W-1:0]   x_scroll [N_OBS];
  logic [10:0]      time_d;
  logic [2:0]       lives_d, level_d;

  function automatic logic [X_W-1:0] spawn_x(input int i);
    return X_W'(SCREEN_W + i * SPACING);
  endfunction

  assign start_edge = start & ~start_q;
  assign div_limit  = fast_mode ? LIM_FAST : LIM_NORM;

  // Comparing against limit-1 with >= lets a switch to fast mode fire immediately.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      divider <= '0;
      tick    <= 1'b0;
      start_q <= 1'b1;
    end else begin
      start_q <= start;
      if (divider >= div_limit) begin
        divider <= '0;
        tick    <= 1'b1;
      end else begin
        divider <= divider + DIV_W'(1);
        tick    <= 1'b0;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      x_scroll[i] = x_q[i] - X_W'(level);
      if (x_q[i] < X_W'(level))
        x_scroll[i] = WRAP_X;
      if (obs_en[i] && x_scroll[i] >= HIT_LO && x_scroll[i] <= HIT_HI)
        hit = 1'b1;
    end
    hit = hit && (player_height < 10'(OBS_H));
  end

  // A hit takes priority over level completion; the last life leaves obstacles where they fell.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    time_d  = game_time;
    lives_d = lives;
    level_d = level;
    case (state_q)
      MENU: begin
        for (int i = 0; i < N_OBS; i++) x_d[i] = spawn_x(i);
        time_d  = '0;
        lives_d = 3'(LIVES);
        level_d = 3'd1;
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (tick) begin
          if (hit) begin
            lives_d = lives - 3'd1;
            if (lives == 3'd1) begin
              state_d = DEATH;
              x_d     = x_scroll;
            end else begin
              for (int i = 0; i < N_OBS; i++) x_d[i] = spawn_x(i);
            end
          end else begin
            x_d = x_scroll;
            if (game_time == 11'(LEVEL_TICKS - 1)) begin
              time_d = '0;
              if (level == 3'(MAX_LEVEL)) state_d = VICTORY;
              else level_d = level + 3'd1;
            end else begin
              time_d = game_time + 11'd1;
            end
          end
        end
      end
      default: begin
        if (start_edge) state_d = MENU;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q   <= MENU;
      game_time <= '0;
      lives     <= 3'(LIVES);
      level     <= 3'd1;
      for (int i = 0; i < N_OBS; i++) x_q[i] <= spawn_x(i);
    end else begin
      state_q   <= state_d;
      game_time <= time_d;
      lives     <= lives_d;
      level     <= level_d;
      x_q       <= x_d;
    end
  end

  for (genvar g = 0; g < N_OBS; g++) begin : g_pack
    assign obs_x[g*X_W +: X_W] = x_q[g];
  end

  assign state          = state_q;
  assign menu_screen    = (state_q == MENU);
  assign victory_screen = (state_q == VICTORY);
  assign player_death   = (state_q == DEATH);

endmodule
